// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/fabric and the SRAM + console slave.
interface ahb_sram_slave_if;
  logic        i_hsel;
  logic [31:0] i_haddr;
  logic [1:0]  i_htrans;
  logic        i_hwrite;
  logic [2:0]  i_hsize;
  logic [2:0]  i_hburst;
  logic [31:0] i_hwdata;
  logic        i_hready;
  logic [31:0] o_hrdata;
  logic        o_hready;
  logic [1:0]  o_hresp;

  // Fabric side: drives the request and HREADY-in, observes the response.
  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
    input  o_hrdata, o_hready, o_hresp
  );

  // Slave side.
  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
    output o_hrdata, o_hready, o_hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave: word-organised SRAM window with optional wait states,
// plus a write-only console TX register with a valid/ready handshake.
module ahb_sram_slave #(
  parameter logic [31:0] ADDR_BASE    = 32'h4000_0000,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h8000_0100
) (
  input  logic                    i_hclk,
  input  logic                    i_hreset,
  ahb_sram_slave_if.slave         bus,
  output logic                    o_console_valid,
  output logic [7:0]              o_console_data,
  input  logic                    i_console_ready
);

  localparam int unsigned LP_IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LP_END      = 33'(ADDR_BASE) + 33'(MEM_WORDS) * 33'd4;
  localparam logic [1:0]  LP_CNT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_CONS = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  logic [31:0] r_mem [MEM_WORDS];

  state_t                r_state;
  logic [1:0]            r_wcnt;
  logic                  r_hready;
  logic [1:0]            r_hresp;
  logic [31:0]           r_hrdata;
  logic                  r_console_valid;
  logic [7:0]            r_console_data;
  logic                  r_dp_wr;
  logic                  r_dp_rd;
  logic [LP_IDX_W-1:0]   r_dp_idx;
  logic [3:0]            r_dp_lanes;

  logic                  w_accept;
  logic                  w_sram_hit;
  logic                  w_cons_hit;
  logic                  w_bad_size;
  logic                  w_misalign;
  logic                  w_error;
  logic [31:0]           w_off;
  logic [LP_IDX_W-1:0]   w_idx;
  logic [3:0]            w_lanes;
  logic                  w_wr_fire;
  logic [31:0]           w_rd_now;
  logic [31:0]           w_rd_wait;
  logic                  w_unused;

  // Replace the enabled byte lanes of a word with new data.
  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Address-phase decode: acceptance, target, lane mask, error class.
  always_comb begin
    w_accept   = bus.i_hsel & bus.i_htrans[1] & bus.i_hready;
    w_off      = bus.i_haddr - ADDR_BASE;
    w_idx      = w_off[LP_IDX_W+1:2];
    w_sram_hit = ({1'b0, bus.i_haddr} >= 33'(ADDR_BASE)) && ({1'b0, bus.i_haddr} < LP_END);
    w_cons_hit = (bus.i_haddr == CONSOLE_ADDR);
    w_bad_size = (bus.i_hsize > 3'd2);
    w_misalign = ((bus.i_hsize == 3'd1) && bus.i_haddr[0]) ||
                 ((bus.i_hsize == 3'd2) && (bus.i_haddr[1:0] != 2'b00));
    w_error    = w_bad_size | w_misalign | (!w_sram_hit && !w_cons_hit) |
                 (!w_sram_hit && w_cons_hit && !bus.i_hwrite);
    case (bus.i_hsize)
      3'd0:    w_lanes = 4'b0001 << bus.i_haddr[1:0];
      3'd1:    w_lanes = bus.i_haddr[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  // A pending SRAM write retires on the edge ending its ready data-phase cycle.
  assign w_wr_fire = r_dp_wr & r_hready;

  // Zero-wait reads see a write retiring on the same edge (bypass merge).
  assign w_rd_now  = (w_wr_fire && (r_dp_idx == w_idx)) ?
                     f_merge(r_mem[w_idx], bus.i_hwdata, r_dp_lanes) : r_mem[w_idx];
  assign w_rd_wait = r_mem[r_dp_idx];

  assign w_unused = ^{w_off, bus.i_hburst, bus.i_htrans[0]};

  // SRAM array: lane-masked write, contents survive reset.
  always_ff @(posedge i_hclk) begin
    if (w_wr_fire && !i_hreset) begin
      r_mem[r_dp_idx] <= f_merge(r_mem[r_dp_idx], bus.i_hwdata, r_dp_lanes);
    end
  end

  // Transfer FSM with registered bus and console outputs.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state         <= ST_IDLE;
      r_wcnt          <= 2'd0;
      r_hready        <= 1'b1;
      r_hresp         <= 2'b00;
      r_hrdata        <= 32'h0;
      r_console_valid <= 1'b0;
      r_console_data  <= 8'h00;
      r_dp_wr         <= 1'b0;
      r_dp_rd         <= 1'b0;
      r_dp_idx        <= '0;
      r_dp_lanes      <= 4'b0000;
    end else begin
      case (r_state)
        // Ready cycles: previous data phase ends here, a new address phase may start.
        ST_IDLE, ST_ERR2: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= 2'b00;
          r_dp_wr  <= 1'b0;
          if (w_accept) begin
            if (w_error) begin
              r_state  <= ST_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 2'b01;
            end else if (w_sram_hit) begin
              r_dp_idx   <= w_idx;
              r_dp_lanes <= w_lanes;
              r_dp_wr    <= bus.i_hwrite;
              r_dp_rd    <= !bus.i_hwrite;
              if (WAIT_STATES == 0) begin
                if (!bus.i_hwrite) r_hrdata <= w_rd_now;
              end else begin
                r_state  <= ST_WAIT;
                r_hready <= 1'b0;
                r_wcnt   <= LP_CNT_INIT;
              end
            end else begin
              r_state  <= ST_CONS;
              r_hready <= 1'b0;
            end
          end
        end
        // Stretch the SRAM data phase; the last wait cycle leads into the ready cycle.
        ST_WAIT: begin
          if (r_wcnt == 2'd0) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            if (r_dp_rd) r_hrdata <= w_rd_wait;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        // Write data arrives in the data phase: capture it, then hold until accepted.
        ST_CONS: begin
          if (!r_console_valid) begin
            r_console_valid <= 1'b1;
            r_console_data  <= bus.i_hwdata[7:0];
          end else if (i_console_ready) begin
            r_console_valid <= 1'b0;
            r_state         <= ST_IDLE;
            r_hready        <= 1'b1;
          end
        end
        // First error cycle; the second one is a ready cycle handled above.
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 2'b01;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= 2'b00;
        end
      endcase
    end
  end

  assign bus.o_hready    = r_hready;
  assign bus.o_hresp     = r_hresp;
  assign bus.o_hrdata    = r_hrdata;
  assign o_console_valid = r_console_valid;
  assign o_console_data  = r_console_data;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 2 and 3 wait states) share one
// stimulus driver; a transfer-level model predicts every output each cycle.
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int unsigned WORDS = 1024;
  localparam logic [31:0] CONS  = 32'h8000_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = 32'h0;
  logic        cready = 1'b0;
  int          sel = 0;

  logic [2:0]  v_hready;
  logic [1:0]  v_hresp [3];
  logic [31:0] v_hrdata [3];
  logic [2:0]  v_cvalid;
  logic [7:0]  v_cdata [3];

  ahb_sram_slave_if bus [3] ();

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign bus[k].i_hsel   = hsel && (sel == k);
    assign bus[k].i_haddr  = haddr;
    assign bus[k].i_htrans = htrans;
    assign bus[k].i_hwrite = hwrite;
    assign bus[k].i_hsize  = hsize;
    assign bus[k].i_hburst = hburst;
    assign bus[k].i_hwdata = hwdata;
    assign bus[k].i_hready = bus[k].o_hready;
    assign v_hready[k]     = bus[k].o_hready;
    assign v_hresp[k]      = bus[k].o_hresp;
    assign v_hrdata[k]     = bus[k].o_hrdata;

    ahb_sram_slave #(
      .ADDR_BASE    (BASE),
      .MEM_WORDS    (WORDS),
      .WAIT_STATES  ((k == 0) ? 0 : k + 1),
      .CONSOLE_ADDR (CONS)
    ) u_dut (
      .i_hclk          (clk),
      .i_hreset        (rst),
      .bus             (bus[k]),
      .o_console_valid (v_cvalid[k]),
      .o_console_data  (v_cdata[k]),
      .i_console_ready (cready)
    );
  end

  // ---------------- model state ----------------
  typedef enum int {K_SRAM, K_CONS, K_ERR} kind_e;

  logic [31:0] ref_mem [int];
  logic        exp_hready = 1'b1;
  logic [1:0]  exp_hresp  = 2'b00;
  logic        exp_cvalid = 1'b0;
  logic [31:0] exp_hrdata [3] = '{32'h0, 32'h0, 32'h0};
  logic [7:0]  exp_cdata  [3] = '{8'h0, 8'h0, 8'h0};
  logic        chk_en = 1'b0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t: got %h want %h", name, sel, $time, act, exp);
    end
  endtask

  function automatic kind_e classify(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    logic [1:0] lo;
    lo = a[1:0];
    if (sz > 3'd2) return K_ERR;
    if (sz == 3'd1 && lo[0]) return K_ERR;
    if (sz == 3'd2 && lo != 2'b00) return K_ERR;
    if (a >= BASE && a < BASE + 32'(4 * WORDS)) return K_SRAM;
    if (a == CONS && wr) return K_CONS;
    return K_ERR;
  endfunction

  // Per-cycle comparison of the selected instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hready", 32'(v_hready[sel]), 32'(exp_hready));
      chk("hresp",  32'(v_hresp[sel]),  32'(exp_hresp));
      chk("hrdata", v_hrdata[sel],      exp_hrdata[sel]);
      chk("cvalid", 32'(v_cvalid[sel]), 32'(exp_cvalid));
      chk("cdata",  32'(v_cdata[sel]),  32'(exp_cdata[sel]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer; the address phase overlaps the current (ready) cycle.
  // Returns positioned in the transfer's final (ready) data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int rdy_lo);
    kind_e       kd;
    int          ws;
    int          len;
    int          key;
    int          nb;
    int          st;
    logic [31:0] w;
    logic [1:0]  lo;
    kd  = classify(wr, a, sz);
    ws  = (sel == 0) ? 0 : sel + 1;
    len = (kd == K_ERR) ? 2 : (kd == K_SRAM) ? ws + 1 : rdy_lo + 3;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hburst = 3'd0;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    for (int d = 1; d <= len; d++) begin
      exp_hready = (d == len);
      exp_hresp  = (kd == K_ERR) ? 2'b01 : 2'b00;
      exp_cvalid = 1'b0;
      cready     = 1'b0;
      if (kd == K_CONS) begin
        if (d >= 2 && d <= rdy_lo + 2) begin
          exp_cvalid     = 1'b1;
          exp_cdata[sel] = wd[7:0];
        end
        cready = (d == rdy_lo + 2);
      end
      if (d == len && kd == K_SRAM) begin
        key = sel * int'(WORDS) + int'((a - BASE) >> 2);
        if (wr) begin
          lo = a[1:0];
          nb = 1 << sz;
          st = int'(lo);
          w  = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
          for (int b = st; b < st + nb; b++) w[8*b +: 8] = wd[8*b +: 8];
          ref_mem[key] = w;
        end else begin
          exp_hrdata[sel] = ref_mem[key];
        end
      end
      if (d < len) step();
    end
  endtask

  // Idle (or BUSY when busy=1) cycles: no data phase, ready OKAY.
  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) begin
      hsel = busy; htrans = busy ? 2'b01 : 2'b00; haddr = BASE;
      step();
      hsel = 1'b0; htrans = 2'b00;
      exp_hready = 1'b1; exp_hresp = 2'b00; exp_cvalid = 1'b0; cready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      chk("rst hready", 32'(v_hready[k]), 32'h1);
      chk("rst hrdata", v_hrdata[k], 32'h0);
      chk("rst cvalid", 32'(v_cvalid[k]), 32'h0);
    end
    sel = 0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2, 1'b0);

    // ---- zero wait states ----
    xfer(1'b1, 32'h4000_0010, 3'd2, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 32'h4000_0010, 3'd2, 32'h0, 0);
    chk("raw rdata", v_hrdata[0], 32'hDEAD_BEEF);
    chk("raw hready", 32'(v_hready[0]), 32'h1);
    xfer(1'b1, 32'h4000_0012, 3'd1, 32'h1234_0000, 0);
    xfer(1'b0, 32'h4000_0010, 3'd2, 32'h0, 0);
    chk("half merge", v_hrdata[0], 32'h1234_BEEF);
    xfer(1'b1, 32'h4000_0011, 3'd0, 32'h0000_7700, 0);
    xfer(1'b0, 32'h4000_0010, 3'd2, 32'h0, 0);
    xfer(1'b1, 32'h4000_0FFC, 3'd2, 32'hCAFE_F00D, 0);
    xfer(1'b0, 32'h4000_0FFC, 3'd2, 32'h0, 0);
    chk("last word", v_hrdata[0], 32'hCAFE_F00D);
    xfer(1'b0, 32'h4000_1000, 3'd2, 32'h0, 0);
    xfer(1'b1, 32'h3FFF_FFFC, 3'd2, 32'h1111_1111, 0);
    xfer(1'b0, 32'h4000_0010, 3'd3, 32'h0, 0);
    xfer(1'b1, 32'h4000_0011, 3'd1, 32'h2222_2222, 0);
    xfer(1'b0, CONS, 3'd0, 32'h0, 0);
    xfer(1'b0, 32'h4000_0010, 3'd2, 32'h0, 0);
    chk("err no effect", v_hrdata[0], 32'h1234_77EF);
    idle(2, 1'b1);
    idle(1, 1'b0);

    // ---- two wait states ----
    sel = 1;
    xfer(1'b1, 32'h4000_0000, 3'd2, 32'h1122_3344, 0);
    xfer(1'b1, 32'h4000_0003, 3'd0, 32'h5A00_0000, 0);
    xfer(1'b0, 32'h4000_0000, 3'd2, 32'h0, 0);
    chk("byte wr ws2", v_hrdata[1], 32'h5A22_3344);
    xfer(1'b0, 32'h4000_0002, 3'd2, 32'h0, 0);
    chk("misalign hresp", 32'(v_hresp[1]), 32'h1);
    xfer(1'b0, 32'h4000_0000, 3'd2, 32'h0, 0);
    chk("misalign no effect", v_hrdata[1], 32'h5A22_3344);
    xfer(1'b1, CONS, 3'd0, 32'h0000_0041, 3);
    chk("console data", 32'(v_cdata[1]), 32'h41);
    chk("console hresp", 32'(v_hresp[1]), 32'h0);
    xfer(1'b1, CONS, 3'd2, 32'h0000_0A0D, 0);
    xfer(1'b0, 32'h4000_0000, 3'd2, 32'h0, 0);
    idle(1, 1'b0);

    // ---- three wait states, reset during a write wait ----
    sel = 2;
    xfer(1'b1, 32'h4000_0020, 3'd2, 32'h0BAD_F00D, 0);
    xfer(1'b0, 32'h4000_0020, 3'd2, 32'h0, 0);
    idle(1, 1'b0);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_0020; hwrite = 1'b1; hsize = 3'd2;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    exp_hready = 1'b0; exp_hresp = 2'b00;
    step();
    rst = 1'b1;
    exp_hready = 1'b1; exp_hresp = 2'b00; exp_cvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_hrdata[k] = 32'h0;
      exp_cdata[k]  = 8'h0;
    end
    #1;
    chk("async rst hready", 32'(v_hready[2]), 32'h1);
    chk("async rst hrdata", v_hrdata[2], 32'h0);
    chk("async rst cdata", 32'(v_cdata[1]), 32'h0);
    step(); step();
    rst = 1'b0;
    idle(1, 1'b0);
    xfer(1'b0, 32'h4000_0020, 3'd2, 32'h0, 0);
    chk("rst keeps word", v_hrdata[2], 32'h0BAD_F00D);
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
